// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor.
//
// One full-adder cell plus a carry flop produce one result bit per clock,
// LSB first. Operands enter through an in_valid/in_ready handshake and the
// result leaves through an out_valid/out_ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds valid until that
// edge. in_ready is high only in IDLE, and out_valid is high only in DONE, so
// the two are never high together.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE and out of reset)
//   op_a/op_b  operands
//   sub        0: A+B, 1: A-B (computed as A + ~B + 1)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   result     sum/difference modulo 2^WIDTH
//   cout       carry out of the MSB (for sub, 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   dbg_state  current FSM state, for debug observation
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, c_msb_q, cout_q, ovf_q;
  logic             sum_bit, carry_next;

  // Single full-adder cell working on the current LSBs.
  assign sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)              state_next = RUN;
      // count saturates at WIDTH once all bits are done; that extra cycle
      // hands over to DONE.
      RUN:     if (count_q == CNT_LAST)   state_next = DONE;
      DONE:    if (out_ready)             state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            b_q     <= op_b ^ {WIDTH{sub}};
            carry_q <= sub;
            count_q <= '0;
          end
        end
        RUN: begin
          if (count_q != CNT_LAST) begin
            result_q <= {sum_bit, result_q[WIDTH-1:1]};
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            carry_q  <= carry_next;
            count_q  <= count_q + CW'(1);
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (count_q == CNT_PRE) c_msb_q <= carry_next;
            if (count_q == CNT_MSB) begin
              cout_q <= carry_next;
              ovf_q  <= c_msb_q ^ carry_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule
